mcp_seq: RTL and testbench

MCP_SEQ -- requirements
Module: mcp_seq

---
 rtl/mcp_seq.sv | 175 +++++++++++++++++
 tb/tb_mcp_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mcp_seq.sv
// mcp_seq -- microprogram sequencer.
//
// Produces the next MicROM fetch address every clock from the sequencing op
// carried by the current microword, with a small return stack for
// microsubroutine calls and trap entry.
//
// Ports
//   pin_clk    in   1   clock, rising edge
//   pin_nrst   in   1   asynchronous active-low reset
//   pin_stall  in   1   freeze sequencing, re-fetch the current microword
//   pin_op     in   3   sequencing op (NEXT/JUMP/CALL/RET/BRANCH/DISPATCH/HOLD)
//   pin_addr   in  11   jump/call/branch target, [10:8] is the dispatch page
//   pin_cond   in   1   branch condition
//   pin_disp   in   8   dispatch offset from the instruction decoder
//   pin_trap   in   1   trap request, level-sensitive
//   pin_lc     out 11   next fetch address (combinational)
//   pin_cur    out 11   address of the microword now on the MicROM output
//   pin_valid  out  1   MicROM output is a valid microword
//   pin_sp     out  3   return stack occupancy
//   pin_err    out  1   sticky stack fault
module mcp_seq #(
  parameter logic [10:0] RESET_LC    = 11'h000,
  parameter logic [10:0] TRAP_LC     = 11'h002,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        pin_clk,
  input  logic        pin_nrst,
  input  logic        pin_stall,
  input  logic [2:0]  pin_op,
  input  logic [10:0] pin_addr,
  input  logic        pin_cond,
  input  logic [7:0]  pin_disp,
  input  logic        pin_trap,
  output logic [10:0] pin_lc,
  output logic [10:0] pin_cur,
  output logic        pin_valid,
  output logic [2:0]  pin_sp,
  output logic        pin_err
);

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_CALL     = 3'd2;
  localparam logic [2:0] OP_RET      = 3'd3;
  localparam logic [2:0] OP_BRANCH   = 3'd4;
  localparam logic [2:0] OP_DISPATCH = 3'd5;

  // Stack storage is rounded up to a power of two so it can be indexed by
  // the low bits of sp without width mismatches; only STACK_DEPTH entries
  // are ever used.
  localparam int         IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int         MEM_N    = 1 << IDX_W;
  localparam logic [2:0] SP_FULL  = 3'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cur_q;
  logic [2:0]  sp_q;
  logic        err_q;
  logic [10:0] stack_mem [MEM_N];

  logic [10:0] lc;
  logic [10:0] cur_inc;
  logic [10:0] tos;
  logic [10:0] push_val;
  logic        push;
  logic        pop;
  logic        fault;
  logic        load_cur;
  logic        valid;

  // 11-bit add wraps 7FF -> 000 naturally, for both fetch and return address.
  assign cur_inc = cur_q + 11'd1;
  assign tos     = stack_mem[IDX_W'(sp_q - 3'd1)];

  always_comb begin
    state_d  = state_q;
    lc       = cur_q;
    valid    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = cur_inc;
    fault    = 1'b0;
    load_cur = 1'b0;
    case (state_q)
      S_INIT: begin
        lc       = RESET_LC;
        load_cur = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        valid = 1'b1;
        if (!pin_stall) begin
          if (pin_trap) begin
            // Return to the pre-empted word itself so it re-executes.
            if (sp_q == SP_FULL) begin
              fault = 1'b1;
            end else begin
              lc       = TRAP_LC;
              push     = 1'b1;
              push_val = cur_q;
            end
          end else begin
            case (pin_op)
              OP_NEXT:     lc = cur_inc;
              OP_JUMP:     lc = pin_addr;
              OP_CALL: begin
                if (sp_q == SP_FULL) begin
                  fault = 1'b1;
                end else begin
                  lc   = pin_addr;
                  push = 1'b1;
                end
              end
              OP_RET: begin
                if (sp_q == 3'd0) begin
                  fault = 1'b1;
                end else begin
                  lc  = tos;
                  pop = 1'b1;
                end
              end
              OP_BRANCH:   lc = pin_cond ? pin_addr : cur_inc;
              OP_DISPATCH: lc = {pin_addr[10:8], pin_disp};
              default:     lc = cur_q;
            endcase
          end
          // A faulting word leaves cur and the fetch address where they are.
          if (fault) begin
            lc      = cur_q;
            state_d = S_FAULT;
          end else begin
            load_cur = 1'b1;
          end
        end
      end
      default: begin
        lc = cur_q;
      end
    endcase
  end

  always_ff @(posedge pin_clk or negedge pin_nrst) begin
    if (!pin_nrst) begin
      state_q <= S_INIT;
      cur_q   <= RESET_LC;
      sp_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_cur) cur_q <= lc;
      if (push)     sp_q  <= sp_q + 3'd1;
      else if (pop) sp_q  <= sp_q - 3'd1;
      if (fault)    err_q <= 1'b1;
    end
  end

  // Stack contents carry no reset; only sp defines what is live.
  always_ff @(posedge pin_clk) begin
    if (push) stack_mem[IDX_W'(sp_q)] <= push_val;
  end

  // Reset forces the fetch address combinationally, not just at the next edge.
  assign pin_lc    = pin_nrst ? lc : RESET_LC;
  assign pin_valid = pin_nrst & valid;
  assign pin_cur   = cur_q;
  assign pin_sp    = sp_q;
  assign pin_err   = err_q;

endmodule

// File: tb/tb_mcp_seq.sv
module tb_mcp_seq;

  logic        pin_clk;
  logic        pin_nrst;
  logic        pin_stall;
  logic [2:0]  pin_op;
  logic [10:0] pin_addr;
  logic        pin_cond;
  logic [7:0]  pin_disp;
  logic        pin_trap;
  logic [10:0] pin_lc;
  logic [10:0] pin_cur;
  logic        pin_valid;
  logic [2:0]  pin_sp;
  logic        pin_err;

  mcp_seq #(
    .RESET_LC   (11'h000),
    .TRAP_LC    (11'h002),
    .STACK_DEPTH(4)
  ) dut (
    .pin_clk  (pin_clk),
    .pin_nrst (pin_nrst),
    .pin_stall(pin_stall),
    .pin_op   (pin_op),
    .pin_addr (pin_addr),
    .pin_cond (pin_cond),
    .pin_disp (pin_disp),
    .pin_trap (pin_trap),
    .pin_lc   (pin_lc),
    .pin_cur  (pin_cur),
    .pin_valid(pin_valid),
    .pin_sp   (pin_sp),
    .pin_err  (pin_err)
  );

  typedef struct {
    string       name;
    logic [10:0] lc;
    logic [10:0] cur;
    logic        valid;
    logic [2:0]  sp;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;

  initial begin
    pin_clk = 1'b0;
    forever #5 pin_clk = ~pin_clk;
  end

  // Monitor: every cycle that has an expectation queued, compare the DUT
  // outputs late in the low phase, well away from the rising edge.
  always @(negedge pin_clk) begin
    exp_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (pin_lc !== e.lc || pin_cur !== e.cur || pin_valid !== e.valid ||
          pin_sp !== e.sp || pin_err !== e.err) begin
        mismatched++;
        $display("FAIL %s: got lc=%h cur=%h valid=%b sp=%0d err=%b, want lc=%h cur=%h valid=%b sp=%0d err=%b",
                 e.name, pin_lc, pin_cur, pin_valid, pin_sp, pin_err,
                 e.lc, e.cur, e.valid, e.sp, e.err);
      end
    end
  end

  task automatic expect_out(input string name, input logic [10:0] lc, input logic [10:0] cur,
                            input logic valid, input logic [2:0] sp, input logic err);
    exp_t e;
    e.name = name; e.lc = lc; e.cur = cur; e.valid = valid; e.sp = sp; e.err = err;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input string name, input logic [2:0] op, input logic [10:0] addr,
                      input logic cond, input logic [7:0] disp, input logic trap,
                      input logic stall, input logic [10:0] lc, input logic [10:0] cur,
                      input logic valid, input logic [2:0] sp, input logic err);
    @(negedge pin_clk);
    #1;
    pin_op = op; pin_addr = addr; pin_cond = cond; pin_disp = disp;
    pin_trap = trap; pin_stall = stall;
    expect_out(name, lc, cur, valid, sp, err);
  endtask

  task automatic do_reset(input string name);
    @(negedge pin_clk);
    #1;
    pin_nrst = 1'b0;
    pin_op = 3'd0; pin_trap = 1'b0; pin_stall = 1'b0;
    expect_out({name, "_in_reset"}, 11'h000, 11'h000, 1'b0, 3'd0, 1'b0);
    @(negedge pin_clk);
    #1;
    pin_nrst = 1'b1;
    expect_out({name, "_init"}, 11'h000, 11'h000, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    pin_nrst = 1'b0; pin_stall = 1'b0; pin_op = 3'd0; pin_addr = 11'h000;
    pin_cond = 1'b0; pin_disp = 8'h00; pin_trap = 1'b0;

    do_reset("por");
    //    name           op    addr    c  disp   tr st   lc      cur    v  sp  err
    step("next0",       3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h001, 11'h000, 1, 3'd0, 0);
    step("next1",       3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h002, 11'h001, 1, 3'd0, 0);
    step("next2",       3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h003, 11'h002, 1, 3'd0, 0);
    step("jump7ff",     3'd1, 11'h7FF, 0, 8'h00, 0, 0, 11'h7FF, 11'h003, 1, 3'd0, 0);
    step("wrap_next",   3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h000, 11'h7FF, 1, 3'd0, 0);
    step("jump7ff_b",   3'd1, 11'h7FF, 0, 8'h00, 0, 0, 11'h7FF, 11'h000, 1, 3'd0, 0);
    step("call_at7ff",  3'd2, 11'h100, 0, 8'h00, 0, 0, 11'h100, 11'h7FF, 1, 3'd0, 0);
    step("ret_wrap",    3'd3, 11'h000, 0, 8'h00, 0, 0, 11'h000, 11'h100, 1, 3'd1, 0);
    step("jump010",     3'd1, 11'h010, 0, 8'h00, 0, 0, 11'h010, 11'h000, 1, 3'd0, 0);
    step("call100",     3'd2, 11'h100, 0, 8'h00, 0, 0, 11'h100, 11'h010, 1, 3'd0, 0);
    step("call200",     3'd2, 11'h200, 0, 8'h00, 0, 0, 11'h200, 11'h100, 1, 3'd1, 0);
    step("ret_101",     3'd3, 11'h000, 0, 8'h00, 0, 0, 11'h101, 11'h200, 1, 3'd2, 0);
    step("ret_011",     3'd3, 11'h000, 0, 8'h00, 0, 0, 11'h011, 11'h101, 1, 3'd1, 0);
    step("next_011",    3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h012, 11'h011, 1, 3'd0, 0);
    step("dispatch",    3'd5, 11'h5FF, 0, 8'h3C, 0, 0, 11'h53C, 11'h012, 1, 3'd0, 0);
    step("branch_t",    3'd4, 11'h0AA, 1, 8'h00, 0, 0, 11'h0AA, 11'h53C, 1, 3'd0, 0);
    step("branch_nt",   3'd4, 11'h0AA, 0, 8'h00, 0, 0, 11'h0AB, 11'h0AA, 1, 3'd0, 0);
    step("hold6",       3'd6, 11'h123, 1, 8'h00, 0, 0, 11'h0AB, 11'h0AB, 1, 3'd0, 0);
    step("hold7",       3'd7, 11'h123, 1, 8'h00, 0, 0, 11'h0AB, 11'h0AB, 1, 3'd0, 0);
    step("jump050",     3'd1, 11'h050, 0, 8'h00, 0, 0, 11'h050, 11'h0AB, 1, 3'd0, 0);
    step("trap_stall",  3'd1, 11'h300, 0, 8'h00, 1, 1, 11'h050, 11'h050, 1, 3'd0, 0);
    step("trap_take",   3'd1, 11'h300, 0, 8'h00, 1, 0, 11'h002, 11'h050, 1, 3'd0, 0);
    step("trap_body",   3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h003, 11'h002, 1, 3'd1, 0);
    step("trap_ret",    3'd3, 11'h000, 0, 8'h00, 0, 0, 11'h050, 11'h003, 1, 3'd1, 0);
    step("after_trap",  3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h051, 11'h050, 1, 3'd0, 0);
    step("nest1",       3'd2, 11'h100, 0, 8'h00, 0, 0, 11'h100, 11'h051, 1, 3'd0, 0);
    step("nest2",       3'd2, 11'h200, 0, 8'h00, 0, 0, 11'h200, 11'h100, 1, 3'd1, 0);
    step("nest3",       3'd2, 11'h300, 0, 8'h00, 0, 0, 11'h300, 11'h200, 1, 3'd2, 0);
    step("nest4",       3'd2, 11'h400, 0, 8'h00, 0, 0, 11'h400, 11'h300, 1, 3'd3, 0);
    step("nest5_ovf",   3'd2, 11'h500, 0, 8'h00, 0, 0, 11'h400, 11'h400, 1, 3'd4, 0);
    step("fault_a",     3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h400, 11'h400, 0, 3'd4, 1);
    step("fault_b",     3'd1, 11'h123, 0, 8'h00, 1, 0, 11'h400, 11'h400, 0, 3'd4, 1);
    do_reset("fault_rst");
    step("post_rst",    3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h001, 11'h000, 1, 3'd0, 0);
    step("ret_undf",    3'd3, 11'h000, 0, 8'h00, 0, 0, 11'h001, 11'h001, 1, 3'd0, 0);
    step("undf_fault",  3'd0, 11'h000, 0, 8'h00, 0, 0, 11'h001, 11'h001, 0, 3'd0, 1);

    repeat (3) @(negedge pin_clk);
    #5;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
